m_btnsw_in: RTL and testbench

M_BTNSW_IN -- requirements
Module: m_btnsw_in

---
 rtl/m_btnsw_in.sv | 109 ++++++++++
 tb/tb_m_btnsw_in.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_btnsw_in.sv
// m_btnsw_in: synchronizes, debounces and edge-detects 5 push buttons and 16 slide switches.
// Ports: CLK, RST_X (async, active-low), w_btn_in[4:0] {u,d,l,r,c}, w_sw_in[15:0] raw inputs;
//        r_btn/r_sw debounced levels, r_btn_press/r_btn_release/r_sw_chg/r_sw_chg_mask pulses.
module m_btnsw_in #(
   parameter int TICK_CYCLES  = 16000,
   parameter int STABLE_TICKS = 4
) (
   input  logic        CLK,
   input  logic        RST_X,
   input  logic [4:0]  w_btn_in,
   input  logic [15:0] w_sw_in,
   output logic [4:0]  r_btn,
   output logic [4:0]  r_btn_press,
   output logic [4:0]  r_btn_release,
   output logic [15:0] r_sw,
   output logic        r_sw_chg,
   output logic [15:0] r_sw_chg_mask
);

   localparam int NB = 21;
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int CW = $clog2(STABLE_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [CW-1:0] ST_LAST = CW'(STABLE_TICKS - 1);

   logic [NB-1:0] sync1;
   logic [NB-1:0] sync2;
   logic [NB-1:0] deb;
   logic [NB-1:0] deb_nxt;
   logic [NB-1:0] acc;
   logic [TW-1:0] tcnt;
   logic          tick;
   logic [CW-1:0] st_cnt [NB];
   logic [CW-1:0] st_nxt [NB];

   // Buttons occupy [4:0], switches [20:5] of every 21-bit vector.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {w_sw_in, w_btn_in};
         sync2 <= sync1;
      end
   end

   assign tick = (tcnt == TICK_LAST);

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         tcnt <= '0;
      end else if (tick) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // A bit is accepted on the tick that completes STABLE_TICKS
   // consecutive samples disagreeing with the debounced level.
   always_comb begin
      deb_nxt = deb;
      acc     = '0;
      for (int i = 0; i < NB; i++) begin
         st_nxt[i] = st_cnt[i];
         if (tick) begin
            if (sync2[i] == deb[i]) begin
               st_nxt[i] = '0;
            end else if (st_cnt[i] == ST_LAST) begin
               st_nxt[i]  = '0;
               deb_nxt[i] = sync2[i];
               acc[i]     = 1'b1;
            end else begin
               st_nxt[i] = st_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         deb    <= '0;
         st_cnt <= '{default: '0};
      end else begin
         deb    <= deb_nxt;
         st_cnt <= st_nxt;
      end
   end

   // Pulses load on the same edge as the level, so they line up
   // with the first cycle the new level is visible.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_btn_press   <= '0;
         r_btn_release <= '0;
         r_sw_chg      <= 1'b0;
         r_sw_chg_mask <= '0;
      end else begin
         r_btn_press   <= acc[4:0] & deb_nxt[4:0];
         r_btn_release <= acc[4:0] & ~deb_nxt[4:0];
         r_sw_chg      <= |acc[20:5];
         r_sw_chg_mask <= acc[20:5];
      end
   end

   assign r_btn = deb[4:0];
   assign r_sw  = deb[20:5];

endmodule

// File: tb/tb_m_btnsw_in.sv
// tb_m_btnsw_in: directed and random checks of m_btnsw_in
// against a sample-window reference model (TICK_CYCLES=4, STABLE_TICKS=3).
module tb_m_btnsw_in;
   localparam int TC = 4;
   localparam int ST = 3;

   logic        CLK = 1'b0;
   logic        RST_X = 1'b0;
   logic [20:0] raw = '0;
   logic [4:0]  w_btn_in;
   logic [15:0] w_sw_in;
   logic [4:0]  r_btn;
   logic [4:0]  r_btn_press;
   logic [4:0]  r_btn_release;
   logic [15:0] r_sw;
   logic        r_sw_chg;
   logic [15:0] r_sw_chg_mask;

   assign w_btn_in = raw[4:0];
   assign w_sw_in  = raw[20:5];

   always #5 CLK = ~CLK;

   m_btnsw_in #(
      .TICK_CYCLES (TC),
      .STABLE_TICKS(ST)
   ) dut (
      .CLK          (CLK),
      .RST_X        (RST_X),
      .w_btn_in     (w_btn_in),
      .w_sw_in      (w_sw_in),
      .r_btn        (r_btn),
      .r_btn_press  (r_btn_press),
      .r_btn_release(r_btn_release),
      .r_sw         (r_sw),
      .r_sw_chg     (r_sw_chg),
      .r_sw_chg_mask(r_sw_chg_mask)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: raw input seen two edges late; on every TC-th
   // edge a sample joins a window of the last ST samples, and a bit
   // flips when its whole window disagrees with its current level.
   logic [20:0] m_q[$];
   logic [20:0] m_win[ST];
   logic [20:0] m_deb;
   logic [20:0] m_acc;
   logic [20:0] m_seen;
   logic [20:0] m_diff;
   int          m_cyc;
   logic [4:0]  e_press;
   logic [4:0]  e_rel;
   logic        e_chg;
   logic [15:0] e_mask;

   always @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         m_q = {};
         m_q.push_back(21'h0);
         m_q.push_back(21'h0);
         for (int i = 0; i < ST; i++) m_win[i] = '0;
         m_deb = '0;
         m_cyc = 0;
         e_press = '0;
         e_rel = '0;
         e_chg = 1'b0;
         e_mask = '0;
      end else begin
         m_seen = m_q.pop_front();
         m_q.push_back(raw);
         m_acc = '0;
         if (m_cyc % TC == TC - 1) begin
            for (int i = ST - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = m_seen;
            m_diff = '1;
            for (int i = 0; i < ST; i++) m_diff &= m_win[i] ^ m_deb;
            m_acc = m_diff;
            m_deb = m_deb ^ m_diff;
         end
         m_cyc++;
         e_press = m_acc[4:0] & m_deb[4:0];
         e_rel   = m_acc[4:0] & ~m_deb[4:0];
         e_chg   = |m_acc[20:5];
         e_mask  = m_acc[20:5];
      end
   end

   int         n_press = 0;
   int         n_rel = 0;
   int         n_chg = 0;
   int         n_btn_hi = 0;
   logic [4:0]  last_press = '0;
   logic [4:0]  last_rel = '0;
   logic [15:0] last_mask = '0;

   always @(negedge CLK) begin
      chk("r_btn", r_btn, m_deb[4:0]);
      chk("r_sw", r_sw, m_deb[20:5]);
      chk("press", r_btn_press, e_press);
      chk("release", r_btn_release, e_rel);
      chk("sw_chg", r_sw_chg, e_chg);
      chk("sw_mask", r_sw_chg_mask, e_mask);
      if (|r_btn_press) begin
         n_press++;
         last_press = r_btn_press;
      end
      if (|r_btn_release) begin
         n_rel++;
         last_rel = r_btn_release;
      end
      if (r_sw_chg) begin
         n_chg++;
         last_mask = r_sw_chg_mask;
      end
      if (|r_btn) n_btn_hi++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic do_reset();
      cyc(1);
      RST_X = 1'b0;
      raw = '0;
      cyc(2);
      RST_X = 1'b1;
   endtask

   int k;
   int s_p;
   int s_r;
   int s_c;
   int s_h;

   initial begin
      do_reset();
      cyc(3);
      chk("rst_btn", r_btn, 5'h0);
      chk("rst_sw", r_sw, 16'h0);

      // Clean press of button c.
      s_p = n_press; s_r = n_rel;
      raw[0] = 1'b1;
      k = 0;
      while (!r_btn[0] && k < 20) begin
         cyc(1);
         k++;
      end
      chk("press_lat_ok", k <= 15, 1'b1);
      cyc(4);
      chk("press_cnt", n_press - s_p, 1);
      chk("press_val", last_press, 5'b00001);
      chk("press_rel_cnt", n_rel - s_r, 0);

      // Short glitch on button u.
      do_reset();
      cyc(4);
      s_p = n_press; s_r = n_rel; s_h = n_btn_hi;
      raw[4] = 1'b1;
      cyc(7);
      raw[4] = 1'b0;
      cyc(20);
      chk("glitch_hi", n_btn_hi - s_h, 0);
      chk("glitch_press", n_press - s_p, 0);
      chk("glitch_rel", n_rel - s_r, 0);

      // All switches change together.
      s_c = n_chg;
      raw[20:5] = 16'hA5A5;
      cyc(20);
      chk("sw_val", r_sw, 16'hA5A5);
      chk("sw_chg_cnt", n_chg - s_c, 1);
      chk("sw_chg_mask", last_mask, 16'hA5A5);

      // Release of button l.
      raw[2] = 1'b1;
      cyc(20);
      chk("l_set", r_btn[2], 1'b1);
      s_p = n_press; s_r = n_rel;
      raw[2] = 1'b0;
      cyc(20);
      chk("rel_cnt", n_rel - s_r, 1);
      chk("rel_val", last_rel, 5'b00100);
      chk("rel_press", n_press - s_p, 0);
      chk("rel_lvl", r_btn[2], 1'b0);

      // Reset in the middle of a switch debounce.
      do_reset();
      raw[8] = 1'b1;
      cyc(9);
      RST_X = 1'b0;
      #1;
      chk("mid_rst_sw", r_sw, 16'h0);
      chk("mid_rst_chg", r_sw_chg, 1'b0);
      chk("mid_rst_btn", r_btn, 5'h0);
      cyc(2);
      s_c = n_chg;
      RST_X = 1'b1;
      cyc(11);
      chk("post_rst_early", r_sw[3], 1'b0);
      cyc(1);
      chk("post_rst_set", r_sw[3], 1'b1);
      chk("post_rst_mask", r_sw_chg_mask, 16'h0008);
      cyc(4);
      chk("post_rst_cnt", n_chg - s_c, 1);

      // Random toggling and glitches, checked cycle by cycle.
      for (int c = 0; c < 20000; c++) begin
         if ($urandom_range(0, 15) == 0) raw[$urandom_range(0, 20)] ^= 1'b1;
         if ($urandom_range(0, 99) == 0) raw = raw ^ 21'($urandom);
         cyc(1);
      end
      cyc(20);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
